// File: rtl/odd_seq_pkg.sv
// Shared types and constants for the odd-value sweep controller.
// ODD_SEQ_PAUSE_EN adds the PAUSE state.
package odd_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
`ifdef ODD_SEQ_PAUSE_EN
        ST_PAUSE = 2'd2,
`endif
        ST_DONE  = 2'd3
    } state_e;

    typedef enum logic [1:0] {
        CMD_HOLD = 2'd0,
        CMD_LOAD = 2'd1,
        CMD_ADD  = 2'd2
    } step_cmd_e;

    localparam int unsigned ODD_RESET_VAL = 32'd1;
    localparam int unsigned ODD_STEP      = 32'd2;

endpackage

// File: rtl/odd_seq_if.sv
// Request/status bundle between a sweep requester (master) and odd_seq_ctrl (slave).
// ODD_SEQ_PAUSE_EN adds the pause request line.
interface odd_seq_if #(
    parameter int WIDTH = 4,
    parameter int REP_W = 4
);
    logic             start;
    logic             stop;
    logic [WIDTH-1:0] target;
    logic [REP_W-1:0] reps;
`ifdef ODD_SEQ_PAUSE_EN
    logic             pause;
`endif
    logic [WIDTH-1:0] count;
    logic             busy;
    logic             done;
    logic             err;

    modport master (
        output start, stop, target, reps,
`ifdef ODD_SEQ_PAUSE_EN
        output pause,
`endif
        input  count, busy, done, err
    );

    modport slave (
        input  start, stop, target, reps,
`ifdef ODD_SEQ_PAUSE_EN
        input  pause,
`endif
        output count, busy, done, err
    );
endinterface

// File: rtl/odd_step.sv
// Odd-value counter register: load to 1, advance by 2 (wrapping), or hold.
module odd_step
    import odd_seq_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  step_cmd_e        cmd,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] count_r;

    // Counter update; the add wraps naturally so the all-ones value returns to 1.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_r <= WIDTH'(ODD_RESET_VAL);
        end else begin
            case (cmd)
                CMD_LOAD: count_r <= WIDTH'(ODD_RESET_VAL);
                CMD_ADD:  count_r <= count_r + WIDTH'(ODD_STEP);
                CMD_HOLD: count_r <= count_r;
                default:  count_r <= count_r;
            endcase
        end
    end

    assign count = count_r;

endmodule

// File: rtl/odd_seq_ctrl.sv
// Sweep controller: counts 1,3,5.. up to a latched odd target, repeated reps times.
// ODD_SEQ_PAUSE_EN enables the pause input and PAUSE state.
module odd_seq_ctrl
    import odd_seq_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int REP_W = 4
) (
    input logic        clk,
    input logic        reset,
    odd_seq_if.slave   bus
);

    state_e           state_r;
    state_e           state_nxt_s;
    step_cmd_e        cmd_s;
    logic [WIDTH-1:0] count_s;
    logic [WIDTH-1:0] tgt_r;
    logic [REP_W-1:0] rem_r;
    logic             busy_r;
    logic             done_r;
    logic             err_r;
    logic             load_s;
    logic             rewind_s;
    logic             err_nxt_s;
    logic             start_ok_s;
    logic             start_bad_s;
    logic             at_tgt_s;
    logic             last_rep_s;
    logic             hold_run_s;

    assign start_ok_s  = bus.start && !bus.stop && bus.target[0];
    assign start_bad_s = bus.start && !bus.stop && !bus.target[0];
    assign at_tgt_s    = (count_s == tgt_r);
    assign last_rep_s  = (rem_r <= REP_W'(1));
`ifdef ODD_SEQ_PAUSE_EN
    assign hold_run_s  = bus.stop || bus.pause;
`else
    assign hold_run_s  = bus.stop;
`endif

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic; stop always outranks pause and completion.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start_ok_s) state_nxt_s = ST_RUN;
                else            state_nxt_s = ST_IDLE;
            end
            ST_RUN: begin
                if (bus.stop)                    state_nxt_s = ST_IDLE;
`ifdef ODD_SEQ_PAUSE_EN
                else if (bus.pause)              state_nxt_s = ST_PAUSE;
`endif
                else if (at_tgt_s && last_rep_s) state_nxt_s = ST_DONE;
                else                             state_nxt_s = ST_RUN;
            end
`ifdef ODD_SEQ_PAUSE_EN
            ST_PAUSE: begin
                if (bus.stop)       state_nxt_s = ST_IDLE;
                else if (bus.pause) state_nxt_s = ST_PAUSE;
                else                state_nxt_s = ST_RUN;
            end
`endif
            ST_DONE: state_nxt_s = ST_IDLE;
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // Counter commands, latch strobes and the error request.
    always_comb begin
        cmd_s     = CMD_HOLD;
        load_s    = 1'b0;
        rewind_s  = 1'b0;
        err_nxt_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start_ok_s) begin
                    cmd_s  = CMD_LOAD;
                    load_s = 1'b1;
                end else begin
                    err_nxt_s = start_bad_s;
                end
            end
            ST_RUN: begin
                if (hold_run_s) begin
                    cmd_s = CMD_HOLD;
                end else if (at_tgt_s) begin
                    if (last_rep_s) begin
                        cmd_s = CMD_HOLD;
                    end else begin
                        cmd_s    = CMD_LOAD;
                        rewind_s = 1'b1;
                    end
                end else begin
                    cmd_s = CMD_ADD;
                end
            end
            default: cmd_s = CMD_HOLD;
        endcase
    end

    // Sweep parameters; a zero repeat count runs one sweep.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tgt_r <= {WIDTH{1'b0}};
            rem_r <= {REP_W{1'b0}};
        end else if (load_s) begin
            tgt_r <= bus.target;
            rem_r <= (bus.reps == {REP_W{1'b0}}) ? REP_W'(1) : bus.reps;
        end else if (rewind_s) begin
            rem_r <= rem_r - REP_W'(1);
        end else begin
            rem_r <= rem_r;
        end
    end

    // Status flags registered from the upcoming state so they align with it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            busy_r <= 1'b0;
            done_r <= 1'b0;
            err_r  <= 1'b0;
        end else begin
`ifdef ODD_SEQ_PAUSE_EN
            busy_r <= (state_nxt_s == ST_RUN) || (state_nxt_s == ST_PAUSE);
`else
            busy_r <= (state_nxt_s == ST_RUN);
`endif
            done_r <= (state_nxt_s == ST_DONE);
            err_r  <= err_nxt_s;
        end
    end

    odd_step #(.WIDTH(WIDTH)) u_step (
        .clk   (clk),
        .reset (reset),
        .cmd   (cmd_s),
        .count (count_s)
    );

    assign bus.count = count_s;
    assign bus.busy  = busy_r;
    assign bus.done  = done_r;
    assign bus.err   = err_r;

endmodule

// File: tb/tb_odd_seq_ctrl.sv
// Directed self-checking bench for odd_seq_ctrl (WIDTH=4, REP_W=4).
module tb_odd_seq_ctrl;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    odd_seq_if #(.WIDTH(4), .REP_W(4)) bus ();

    odd_seq_ctrl #(.WIDTH(4), .REP_W(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic expect_st(input string tag, input logic [3:0] cnt, input logic b,
                             input logic d, input logic e);
        chk({tag, ".count"}, {28'd0, bus.count}, {28'd0, cnt});
        chk({tag, ".busy"},  {31'd0, bus.busy},  {31'd0, b});
        chk({tag, ".done"},  {31'd0, bus.done},  {31'd0, d});
        chk({tag, ".err"},   {31'd0, bus.err},   {31'd0, e});
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic req(input logic [3:0] tgt, input logic [3:0] rp);
        bus.target = tgt;
        bus.reps   = rp;
        bus.start  = 1'b1;
    endtask

    initial begin
        checks     = 0;
        errors     = 0;
        reset      = 1'b0;
        bus.start  = 1'b0;
        bus.stop   = 1'b0;
        bus.target = 4'd0;
        bus.reps   = 4'd0;
`ifdef ODD_SEQ_PAUSE_EN
        bus.pause  = 1'b0;
`endif
        // Reset held for two cycles
        tick();
        tick();
        expect_st("reset", 4'd1, 1'b0, 1'b0, 1'b0);
        reset = 1'b1;
        tick();
        expect_st("idle", 4'd1, 1'b0, 1'b0, 1'b0);

        // Single sweep to 5
        req(4'd5, 4'd1);
        tick(); expect_st("s5_c1", 4'd1, 1'b1, 1'b0, 1'b0);
        bus.start = 1'b0;
        tick(); expect_st("s5_c3", 4'd3, 1'b1, 1'b0, 1'b0);
        tick(); expect_st("s5_c5", 4'd5, 1'b1, 1'b0, 1'b0);
        tick(); expect_st("s5_done", 4'd5, 1'b0, 1'b1, 1'b0);
        tick(); expect_st("s5_idle", 4'd5, 1'b0, 1'b0, 1'b0);

        // Two sweeps to 3
        req(4'd3, 4'd2);
        tick(); expect_st("r3_a1", 4'd1, 1'b1, 1'b0, 1'b0);
        bus.start = 1'b0;
        tick(); expect_st("r3_a3", 4'd3, 1'b1, 1'b0, 1'b0);
        tick(); expect_st("r3_b1", 4'd1, 1'b1, 1'b0, 1'b0);
        tick(); expect_st("r3_b3", 4'd3, 1'b1, 1'b0, 1'b0);
        tick(); expect_st("r3_done", 4'd3, 1'b0, 1'b1, 1'b0);
        tick(); expect_st("r3_idle", 4'd3, 1'b0, 1'b0, 1'b0);

        // Even target rejected
        req(4'd4, 4'd1);
        tick(); expect_st("even_err", 4'd3, 1'b0, 1'b0, 1'b1);
        bus.start = 1'b0;
        tick(); expect_st("even_after", 4'd3, 1'b0, 1'b0, 1'b0);

        // Start with stop: stop wins, even for an even target
        req(4'd5, 4'd1);
        bus.stop = 1'b1;
        tick(); expect_st("ss_odd", 4'd3, 1'b0, 1'b0, 1'b0);
        bus.target = 4'd6;
        tick(); expect_st("ss_even", 4'd3, 1'b0, 1'b0, 1'b0);
        bus.start = 1'b0;
        bus.stop  = 1'b0;

        // Abort at count 3
        req(4'd9, 4'd1);
        tick(); expect_st("ab_c1", 4'd1, 1'b1, 1'b0, 1'b0);
        bus.start = 1'b0;
        tick(); expect_st("ab_c3", 4'd3, 1'b1, 1'b0, 1'b0);
        bus.stop = 1'b1;
        tick(); expect_st("ab_stop", 4'd3, 1'b0, 1'b0, 1'b0);
        bus.stop = 1'b0;
        tick(); expect_st("ab_after", 4'd3, 1'b0, 1'b0, 1'b0);

        // Target 1, reps 0: one RUN cycle then done
        req(4'd1, 4'd0);
        tick(); expect_st("t1_run", 4'd1, 1'b1, 1'b0, 1'b0);
        bus.start = 1'b0;
        tick(); expect_st("t1_done", 4'd1, 1'b0, 1'b1, 1'b0);
        tick(); expect_st("t1_idle", 4'd1, 1'b0, 1'b0, 1'b0);

        // Full-range sweep to 15; a start while busy is ignored
        req(4'd15, 4'd0);
        tick(); expect_st("t15_c1", 4'd1, 1'b1, 1'b0, 1'b0);
        bus.target = 4'd1;
        for (int i = 1; i < 8; i++) begin
            tick(); expect_st("t15_run", 4'(2 * i + 1), 1'b1, 1'b0, 1'b0);
        end
        bus.start = 1'b0;
        tick(); expect_st("t15_done", 4'd15, 1'b0, 1'b1, 1'b0);
        tick(); expect_st("t15_idle", 4'd15, 1'b0, 1'b0, 1'b0);

`ifdef ODD_SEQ_PAUSE_EN
        // Pause at 5 for three cycles, then resume
        req(4'd9, 4'd1);
        tick(); expect_st("pz_c1", 4'd1, 1'b1, 1'b0, 1'b0);
        bus.start = 1'b0;
        tick(); expect_st("pz_c3", 4'd3, 1'b1, 1'b0, 1'b0);
        tick(); expect_st("pz_c5", 4'd5, 1'b1, 1'b0, 1'b0);
        bus.pause = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick(); expect_st("pz_hold", 4'd5, 1'b1, 1'b0, 1'b0);
        end
        bus.pause = 1'b0;
        tick(); expect_st("pz_resume", 4'd5, 1'b1, 1'b0, 1'b0);
        tick(); expect_st("pz_c7", 4'd7, 1'b1, 1'b0, 1'b0);
        bus.pause = 1'b1;
        bus.stop  = 1'b1;
        tick(); expect_st("pz_stop", 4'd7, 1'b0, 1'b0, 1'b0);
        bus.pause = 1'b0;
        bus.stop  = 1'b0;
`endif

        // Reset mid-sweep at count 7
        req(4'd9, 4'd1);
        tick(); expect_st("mr_c1", 4'd1, 1'b1, 1'b0, 1'b0);
        bus.start = 1'b0;
        tick(); expect_st("mr_c3", 4'd3, 1'b1, 1'b0, 1'b0);
        tick(); expect_st("mr_c5", 4'd5, 1'b1, 1'b0, 1'b0);
        tick(); expect_st("mr_c7", 4'd7, 1'b1, 1'b0, 1'b0);
        reset = 1'b0;
        #1;
        expect_st("mr_async", 4'd1, 1'b0, 1'b0, 1'b0);
        tick();
        reset = 1'b1;
        tick(); expect_st("mr_idle1", 4'd1, 1'b0, 1'b0, 1'b0);
        tick(); expect_st("mr_idle2", 4'd1, 1'b0, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/odd_seq_ctrl.md
ODD_SEQ_CTRL -- requirements
Module: odd_seq_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 4, counter width in bits.
REQ-002 SHALL have parameter REP_W, default 4, repeat-count width in bits.
REQ-003 SHALL have port clk, input, 1, the single clock; all state changes on rising edge.
REQ-004 SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port start, input, 1, request to begin a sweep; sampled only in IDLE.
REQ-006 SHALL have port stop, input, 1, abort the current sweep.
REQ-007 SHALL have port target, input, WIDTH, final odd value of each sweep; sampled with start.
REQ-008 SHALL have port reps, input, REP_W, number of sweeps; sampled with start.
REQ-009 SHALL have port pause, input, 1, freeze the count; present only when ODD_SEQ_PAUSE_EN is defined.
REQ-010 SHALL have port count, output, WIDTH, current odd counter value.
REQ-011 SHALL have port busy, output, 1, high in RUN and PAUSE.
REQ-012 SHALL have port done, output, 1, one-cycle pulse at normal sweep completion.
REQ-013 SHALL have port err, output, 1, one-cycle pulse on a rejected start.

Function
REQ-014 SHALL implement the states IDLE, RUN, PAUSE and DONE; all outputs are registered.
REQ-015 In IDLE, start=1, stop=0 and target[0]=1 SHALL latch target and reps (reps=0 is treated as 1), load count=1 and enter RUN on the next edge.
REQ-016 In IDLE, start=1 with target[0]=0 SHALL pulse err for one cycle, keep the state at IDLE and leave count unchanged.
REQ-017 In IDLE, start and stop asserted together SHALL have stop win: no transition and no err.
REQ-018 In RUN with count != latched target, count SHALL advance by 2 modulo 2^WIDTH, so 2^WIDTH-1 wraps to 1.
REQ-019 In RUN with count == latched target and remaining reps > 1, the next count SHALL be 1 and remaining reps SHALL decrement.
REQ-020 In RUN with count == latched target and remaining reps == 1, count SHALL hold and the state SHALL go to DONE.
REQ-021 DONE SHALL last exactly one cycle with done=1 and busy=0, then return to IDLE with count held.
REQ-022 stop=1 in RUN or PAUSE SHALL go to IDLE on the next edge, hold count and not assert done.
REQ-023 start SHALL be ignored while busy=1.
REQ-024 Target 1 SHALL complete one sweep in one RUN cycle.

Reset
REQ-025 While reset=0, the block SHALL asynchronously force state=IDLE, count=1, busy=0, done=0, err=0 and clear the latched target and reps to 0.
REQ-026 Reset asserted mid-sweep SHALL discard the sweep with no done pulse.

Configuration
REQ-027 With macro ODD_SEQ_PAUSE_EN defined, pause=1 in RUN SHALL enter PAUSE with count frozen, and pause=0 SHALL resume RUN on the next edge.
REQ-028 With ODD_SEQ_PAUSE_EN defined, stop SHALL have priority over pause.
REQ-029 Without ODD_SEQ_PAUSE_EN, the pause port and the PAUSE state SHALL be absent, and RUN SHALL never freeze.

Structure
REQ-030 Package odd_seq_pkg SHALL hold the state enum typedef and the constants ODD_RESET_VAL=1 and ODD_STEP=2.
REQ-031 Sub-module odd_step SHALL hold the count register with load-to-1, add-2 and hold controls.
REQ-032 odd_seq_ctrl SHALL drive the odd_step controls from its state machine.

Verification
REQ-033 Reset scenario: hold reset=0 for 2 cycles -> count=1, busy=0, done=0, err=0.
REQ-034 Single sweep: target=5, reps=1, start pulse -> count 1,3,5 on the next three cycles, then done=1 with count=5, then IDLE.
REQ-035 Repeated sweep: target=3, reps=2 -> count 1,3,1,3, then a single done pulse.
REQ-036 Even target: target=4 with a start pulse -> err=1 for one cycle, busy=0 throughout.
REQ-037 Abort: target=9, stop asserted when count=3 -> IDLE next cycle, count=3, no done.
REQ-038 Mid-sweep reset and pause: reset=0 at count=7 -> count=1 immediately; with ODD_SEQ_PAUSE_EN, pause held 3 cycles at count=5 -> count stays 5, then continues 7.
